// File: rtl/gray_tick_ctrl.sv
// rtl/gray_tick_ctrl.sv - debounced run/step/speed tick controller driving the Gray counter clk_en
// Optional speed selection is compiled in with GRAY_TICK_SPEED_EN.
module gray_tick_ctrl #(
    parameter int DISTANCE = 100000000,
    parameter int DEBOUNCE = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_speed,
    output logic       pulse,
    output logic       running,
    output logic [1:0] speed
);
    localparam int DW = $clog2(DEBOUNCE);
    localparam int CW = $clog2(DISTANCE);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
    localparam logic [CW:0] DIST_FULL = (CW + 1)'(DISTANCE);
    localparam int B_RUN  = 0;
    localparam int B_STEP = 1;
`ifdef GRAY_TICK_SPEED_EN
    localparam int NB      = 3;
    localparam int B_SPEED = 2;
`else
    localparam int NB = 2;
`endif

    typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_t;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q, sync2_q, stable_q, prev_q, evt_q;
    logic [DW-1:0] db_cnt_q [NB];

`ifdef GRAY_TICK_SPEED_EN
    assign btn_raw = {btn_speed, btn_step, btn_run};
`else
    logic unused_btn_speed;
    assign unused_btn_speed = btn_speed;
    assign btn_raw = {btn_step, btn_run};
`endif

    // Each button: 2-FF sync, debounce against the accepted level, registered rising edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            evt_q    <= '0;
            for (int b = 0; b < NB; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= stable_q;
            evt_q   <= stable_q & ~prev_q;
            for (int b = 0; b < NB; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_LAST) begin
                    stable_q[b] <= sync2_q[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DW'(1);
                end
            end
        end
    end

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic [CW:0]   limit;
    logic          run_evt, step_evt, spd_evt;
    logic          at_last, step_ok;

    assign run_evt  = evt_q[B_RUN];
    assign step_evt = evt_q[B_STEP];

`ifdef GRAY_TICK_SPEED_EN
    logic [1:0] speed_q;
    assign spd_evt = evt_q[B_SPEED];
    assign limit   = DIST_FULL >> speed_q;
    assign speed   = speed_q;
`else
    assign spd_evt = 1'b0;
    assign limit   = DIST_FULL;
    assign speed   = 2'b00;
`endif

    assign at_last = ({1'b0, cnt_q} == limit - (CW + 1)'(1));
    // A run toggle in the same cycle wins over a step.
    assign step_ok = step_evt && (state_q == PAUSED) && !run_evt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUNNING;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
`ifdef GRAY_TICK_SPEED_EN
            speed_q <= 2'd0;
`endif
        end else begin
            pulse_q <= ((state_q == RUNNING) && at_last && !run_evt && !spd_evt) || step_ok;
            if (run_evt) state_q <= (state_q == RUNNING) ? PAUSED : RUNNING;
            if (run_evt || spd_evt || (state_q != RUNNING) || at_last) cnt_q <= '0;
            else cnt_q <= cnt_q + CW'(1);
`ifdef GRAY_TICK_SPEED_EN
            if (spd_evt) speed_q <= speed_q + 2'd1;
`endif
        end
    end

    assign pulse   = pulse_q;
    assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_gray_tick_ctrl.sv
// tb/tb_gray_tick_ctrl.sv - directed self-checking bench for gray_tick_ctrl (DISTANCE=16, DEBOUNCE=4)
module tb_gray_tick_ctrl;
    logic       clk;
    logic       rst;
    logic       btn_run, btn_step, btn_speed;
    logic       pulse, running;
    logic [1:0] speed;
    int total = 0;
    int bad   = 0;

    gray_tick_ctrl #(.DISTANCE(16), .DEBOUNCE(4)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
        .btn_speed(btn_speed), .pulse(pulse), .running(running), .speed(speed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic press(input int b);
        @(negedge clk);
        if (b == 0) btn_run = 1'b1; else if (b == 1) btn_step = 1'b1; else btn_speed = 1'b1;
        repeat (10) @(negedge clk);
        btn_run = 1'b0; btn_step = 1'b0; btn_speed = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Returns cycles between two consecutive pulses, or -1 if no pulse pair occurs within 40 cycles each.
    task automatic measure_period(output int p);
        bit seen;
        bit done;
        int c;
        seen = 1'b0;
        done = 1'b0;
        c = 0;
        p = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pulse) seen = 1'b1;
        end
        if (seen) begin
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                c++;
                if (pulse) begin
                    p = c;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; btn_run = 1'b0; btn_step = 1'b0; btn_speed = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (running !== 1'b1 || speed !== 2'd0 || pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: running=%b speed=%0d pulse=%b want 1 0 0", running, speed, pulse);
        end
        rst = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            total++;
            if (pulse !== ((k % 16) == 0)) begin
                bad++;
                $display("FAIL reset_period edge %0d: pulse=%b want %b", k, pulse, (k % 16) == 0);
            end
        end
    endtask

    task automatic test_speed;
        int p;
`ifdef GRAY_TICK_SPEED_EN
        int exp_per [4] = '{8, 4, 2, 16};
        for (int n = 0; n < 4; n++) begin
            press(2);
            total++;
            if (speed !== 2'((n + 1) % 4)) begin
                bad++;
                $display("FAIL speed_value press %0d: speed=%0d want %0d", n, speed, (n + 1) % 4);
            end
            measure_period(p);
            total++;
            if (p !== exp_per[n]) begin
                bad++;
                $display("FAIL speed_period press %0d: period=%0d want %0d", n, p, exp_per[n]);
            end
        end
`else
        for (int n = 0; n < 3; n++) press(2);
        total++;
        if (speed !== 2'd0) begin
            bad++;
            $display("FAIL speed_disabled: speed=%0d want 0", speed);
        end
        measure_period(p);
        total++;
        if (p !== 16) begin
            bad++;
            $display("FAIL speed_disabled_period: period=%0d want 16", p);
        end
`endif
    endtask

    task automatic test_run_bounce;
        int toggles;
        logic prev;
        toggles = 0;
        prev = running;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn_run = ((i / 2) % 2) == 0;
            if (running !== prev) toggles++;
            prev = running;
        end
        @(negedge clk);
        if (running !== prev) toggles++;
        prev = running;
        btn_run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (running !== prev) toggles++;
            prev = running;
            total++;
            if (running !== (i < 7)) begin
                bad++;
                $display("FAIL run_toggle edge %0d: running=%b want %b", i, running, i < 7);
            end
            if (i >= 7) begin
                total++;
                if (pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL run_paused_pulse edge %0d: pulse=%b want 0", i, pulse);
                end
            end
        end
        btn_run = 1'b0;
        repeat (15) @(negedge clk);
        if (running !== prev) toggles++;
        total++;
        if (toggles !== 1 || running !== 1'b0) begin
            bad++;
            $display("FAIL run_bounce_count: toggles=%0d running=%b want 1 0", toggles, running);
        end
    endtask

    task automatic test_step;
        @(negedge clk);
        btn_step = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 9) btn_step = 1'b0;
            total++;
            if (pulse !== (k == 7) || running !== 1'b0) begin
                bad++;
                $display("FAIL step edge %0d: pulse=%b running=%b want %b 0", k, pulse, running, k == 7);
            end
        end
    endtask

    task automatic test_run_step_same;
        @(negedge clk);
        btn_run = 1'b1;
        btn_step = 1'b1;
        for (int k = 0; k < 31; k++) begin
            @(negedge clk);
            if (k == 9) begin
                btn_run = 1'b0;
                btn_step = 1'b0;
            end
            total++;
            if (running !== (k >= 7) || pulse !== (k == 23)) begin
                bad++;
                $display("FAIL run_step_same edge %0d: running=%b pulse=%b want %b %b",
                         k, running, pulse, k >= 7, k == 23);
            end
        end
    endtask

    task automatic test_reset_mid;
`ifdef GRAY_TICK_SPEED_EN
        press(2);
        press(2);
        total++;
        if (speed !== 2'd2) begin
            bad++;
            $display("FAIL mid_setup_speed: speed=%0d want 2", speed);
        end
`endif
        press(0);
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL mid_setup_run: running=%b want 0", running);
        end
        btn_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (running !== 1'b1 || speed !== 2'd0 || pulse !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_state: running=%b speed=%0d pulse=%b want 1 0 0", running, speed, pulse);
        end
        rst = 1'b1;
        btn_run = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            total++;
            if (pulse !== ((k % 16) == 0) || running !== 1'b1) begin
                bad++;
                $display("FAIL mid_reset_period edge %0d: pulse=%b running=%b want %b 1",
                         k, pulse, running, (k % 16) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_speed();
        test_run_bounce();
        test_step();
        test_run_step_same();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/gray_tick_ctrl.md
# gray_tick_ctrl

Upstream tick controller for the Gray-counter system. It replaces the free-running pulse generator and drives the counter's `clk_en` input. Three push-buttons are synchronised and debounced, and give run/pause, single-step and speed selection. The `pulse` output feeds `gray_Nbits.clk_en` directly: one single-cycle pulse per count.

## Interface
- `DISTANCE`, 100000000: clock cycles per tick at speed 0 (1 Hz at a 10 ns clock). Must be ≥ 16.
- `DEBOUNCE`, 1000000: number of consecutive cycles a synchronised button must differ from its stable state before that state is accepted (10 ms). Must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `btn_run`  in  1  raw asynchronous button; each press toggles run/pause.
- `btn_step`  in  1  raw asynchronous button; each press issues one pulse while paused.
- `btn_speed`  in  1  raw asynchronous button; each press advances the speed 0→1→2→3→0.
- `pulse`  out  1  registered single-cycle tick to the counter's `clk_en`.
- `running`  out  1  1 = RUNNING state, 0 = PAUSED.
- `speed`  out  2  current speed index.

## Operation
- Button path, one instance per button:
  - 2-FF synchroniser, then a debounce counter of width `$clog2(DEBOUNCE)`.
  - The counter increments each cycle the synchroniser output differs from `stable`, and clears when they are equal.
  - On the cycle the counter would reach `DEBOUNCE`, `stable` takes the synchroniser value and the counter clears.
  - A registered rising-edge detector on `stable` produces a one-cycle event.
- State machine, `RUNNING`/`PAUSED`:
  - A run event toggles the state.
  - A step event in PAUSED sets `pulse` for one cycle. A step event in RUNNING is ignored.
- Speed:
  - A speed event increments `speed` modulo 4 (3 wraps to 0).
  - `limit = DISTANCE >> speed`.
- Prescaler:
  - Counter `cnt` of width `$clog2(DISTANCE)` counts 0..limit-1 and wraps to 0.
  - `cnt` advances only while RUNNING; it is held at 0 while PAUSED.
  - `cnt` is cleared to 0 on any run or speed event.
- Pulse: `pulse` is registered and equals (RUNNING and `cnt == limit-1` and no run/speed event this cycle) OR (an accepted step event).
- Simultaneous events:
  - Run and step in the same cycle: the run toggle applies and the step is dropped.
  - Speed and step in the same cycle, while paused: both apply.
  - A run or speed event coinciding with `cnt == limit-1`: no pulse, and `cnt` is cleared.
- Reset values:
  - `running = 1`, `speed = 0`, `pulse = 0`, `cnt = 0`.
  - All synchronisers, `stable` bits, debounce counters and edge registers are 0.
- Reset mid-operation: the next cycle after `rst` goes low matches the reset values regardless of state. Pending button activity is discarded.

## Timing
- Button latency: a raw level first sampled at edge 0 sets `stable` at edge `DEBOUNCE+1`. The event is high after edge `DEBOUNCE+2`. `running`, `speed` and the step `pulse` update at edge `DEBOUNCE+3`.
- Glitches shorter than `DEBOUNCE` consecutive synchronised cycles produce no event.
- Releasing a button produces no event; only a press (rising `stable`) does.
- Run period: `pulse` is high for exactly one cycle every `limit` cycles. `pulse` is never high in two consecutive cycles unless a step follows a wrap, which is impossible because steps are only accepted while PAUSED.
- After reset release (or PAUSED→RUNNING), the first `pulse` is high in the cycle after edge `limit` (counting the first edge with `cnt` = 0 as edge 1).

## Configuration
- `GRAY_TICK_SPEED_EN` defined:
  - Speed button path, `speed` register and variable `limit` are compiled in, as described above.
- `GRAY_TICK_SPEED_EN` undefined:
  - No `btn_speed` debouncer is built and the input is ignored.
  - `speed` is tied to 2'b00.
  - `limit` is the constant `DISTANCE`.

## Test plan
All scenarios use `DISTANCE=16`, `DEBOUNCE=4`, with `GRAY_TICK_SPEED_EN` defined unless stated.
- Release reset with buttons idle → `running=1`, `speed=0`. `pulse` is high 1 cycle in 16, first after edge 16, for 64 cycles (4 pulses).
- `btn_run` toggles every 2 cycles for 20 cycles, then is held at 1 → exactly one toggle (`running=0`), and no `pulse` afterwards over 50 cycles.
- PAUSED, `btn_step` pressed for 10 cycles then released → exactly one `pulse`, `DEBOUNCE+3`=7 edges after the first sample. `cnt` stays 0. Releasing produces nothing.
- Three clean `btn_speed` presses → `speed` steps 1, 2, 3 and the pulse period is 8, 4, then 2. A fourth press wraps to `speed=0`, period 16. Rebuilt without the macro: presses have no effect and the period stays 16.
- `btn_run` and `btn_step` stable-high in the same cycle while PAUSED → `running=1` and no step pulse. The first run pulse comes 16 cycles later.
- `rst` asserted for 1 cycle mid-run with `speed=2`, `running=0` → next cycle `running=1`, `speed=0`, `pulse=0`, then a 16-cycle period.
